// File: rtl/lsu_master_if.sv
// Request/grant/response bus between the load/store master and the external
// word-addressed memory.
interface lsu_master_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/lsu_master.sv
// LW/SW bus master for the single-cycle MIPS core: stalls the core while an
// access is in flight and drives the register-file write-back value.
module lsu_master #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [31:0] Ins,
   input  logic [31:0] Result,
   input  logic [31:0] Rdata2,
   input  logic [31:0] nextPC,
   output logic [31:0] Wdata,
   output logic        Stall,
   output logic        Err,
   lsu_master_if.master mem
);

   localparam logic [5:0] LW   = 6'h23;
   localparam logic [5:0] SW   = 6'h2b;
   localparam logic [5:0] JAL  = 6'h03;
   localparam logic [5:0] JALR = 6'h09;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t             state;
   logic [31:0]        addr_q, wdata_q, rdata_q;
   logic               we_q, req_q;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [5:0]         op, funct;
   logic               is_mem, tmo;
   logic               unused_ins;

   assign op         = Ins[31:26];
   assign funct      = Ins[5:0];
   assign unused_ins = ^Ins[25:6];
   assign is_mem     = (op == LW) || (op == SW);

   // Saturating increment; the access times out on the cycle it would reach TIMEOUT.
   assign cnt_nxt = (cnt == CNT_W'(TIMEOUT)) ? cnt : cnt + 1'b1;
   assign tmo     = (cnt_nxt == CNT_W'(TIMEOUT));

   assign Stall = ((state == S_IDLE) && is_mem) || (state == S_REQ) || (state == S_WAIT);
   assign Err   = (state == S_WAIT) && !mem.mem_rvalid && tmo;

   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

   always_comb begin
      Wdata = Result;
      if (op == LW)                          Wdata = rdata_q;
      else if (op == JAL)                    Wdata = nextPC;
      else if ((op == 6'h00) && (funct == JALR)) Wdata = nextPC;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state   <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         req_q   <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            S_IDLE: if (is_mem) begin
               addr_q  <= Result;
               wdata_q <= Rdata2;
               we_q    <= (op == SW);
               req_q   <= 1'b1;
               state   <= S_REQ;
            end
            // rvalid is not looked at here: data may only follow the grant cycle.
            S_REQ: if (mem.mem_gnt) begin
               req_q <= 1'b0;
               cnt   <= '0;
               state <= we_q ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
               if (mem.mem_rvalid) begin
                  rdata_q <= mem.mem_rdata;
                  state   <= S_DONE;
               end else if (tmo) begin
                  rdata_q <= '0;
                  state   <= S_DONE;
               end else begin
                  cnt <= cnt_nxt;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/lsu_master.md
# lsu_master

Load/store bus master for the single-cycle MIPS core. It takes over LW and SW from the core's internal data-memory path and performs them on an external word-addressed memory over a request/grant/response handshake. While the access is in flight it stalls the core, then drives the register-file write-back value (`Wdata`) with the same selection rules as the existing write-back mux. It sits between the ALU/register-file outputs and the write-back port, with the memory responder on the far side.

## Interface

**Parameters**
- `TIMEOUT`, default 255: maximum number of WAIT cycles allowed for a load response before an error is declared.
- `CNT_W`, default 8: width of the timeout counter; must satisfy `2^CNT_W > TIMEOUT`.

**Ports** (clock and reset first)
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: reset, synchronous and active-low.
- `Ins` in 32: current instruction. `Ins[31:26]` is the opcode; `Ins[5:0]` is funct.
- `Result` in 32: ALU result. Used as the word address for LW/SW and as the default write-back value.
- `Rdata2` in 32: store data.
- `nextPC` in 32: PC+4, the write-back value for JAL and JALR.
- `Wdata` out 32: register-file write-back value.
- `Stall` out 1: when high, the core holds its PC and suppresses register-file and DM writes.
- `Err` out 1: one-cycle pulse on a load timeout.
- `mem_req` out 1: request valid.
- `mem_we` out 1: 1 for a store, 0 for a load.
- `mem_addr` out 32: word address.
- `mem_wdata` out 32: store data.
- `mem_gnt` in 1: responder accepts the request in this cycle.
- `mem_rvalid` in 1: load data valid.
- `mem_rdata` in 32: load data.

## Operation

**Opcodes.** Decoded with the shared constants `LW`, `SW`, `JAL` and `JALR` (funct) from `common_param.vh`.

**States:** IDLE, REQ, WAIT, DONE.

**IDLE**
- If the opcode is LW or SW:
  - Capture `Result`→`addr_q`, `Rdata2`→`wdata_q`, and is-store→`we_q`.
  - Go to REQ.
  - `Stall` = 1 combinationally in this cycle.
- Otherwise remain in IDLE with `Stall` = 0.

**REQ**
- `mem_req` = 1, and `mem_addr`, `mem_we`, `mem_wdata` = captured registers. These are held stable until grant.
- On `mem_gnt`:
  - store → DONE
  - load → WAIT, with the counter cleared
- `Stall` = 1.

**WAIT**
- On `mem_rvalid`: `mem_rdata`→`rdata_q`, go to DONE.
- Otherwise increment the counter.
- If the counter reaches `TIMEOUT` without `mem_rvalid`: `rdata_q` = 0, `Err` = 1 for that cycle, go to DONE.
- `Stall` = 1.

**DONE**
- `Stall` = 0 for exactly one cycle, so the core commits this instruction on the ending edge.
- Always return to IDLE. No new access is started in DONE.

**Write-back mux** (combinational, every state)
- opcode LW → `rdata_q`
- JAL → `nextPC`
- opcode 0 with funct JALR → `nextPC`
- else → `Result`

**Outside REQ:** `mem_req` = 0; `mem_addr`, `mem_we`, `mem_wdata` keep their last captured values.

## Timing

**Reset** (`RST_N` = 0 at a rising edge):
- state = IDLE; `addr_q`, `wdata_q`, `rdata_q` and the counter = 0; `we_q` = 0.
- Outputs: `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `Err` = 0.
- `Stall` then follows IDLE decode. `Wdata` follows the mux.
- Reset mid-access: the request is dropped immediately. A late `mem_rvalid` arriving in IDLE, REQ or DONE is ignored.

**Latency**
- Minimum load: IDLE (stall), REQ with gnt, WAIT with rvalid, DONE. That is 3 stall cycles, and the core commits on the 4th edge.
- Minimum store: IDLE, REQ with gnt, DONE. That is 2 stall cycles.
- Each extra gnt or rvalid wait adds one stall cycle.

**Handshake rules**
- A `mem_rvalid` in the same cycle as `mem_gnt` is ignored. The responder must return data no earlier than the cycle after grant.
- A `mem_rvalid` in WAIT on the same cycle the counter reaches `TIMEOUT`: data wins and `Err` stays 0.
- `mem_gnt` outside REQ is ignored.

**Ordering**
- Back-to-back LW/SW instructions each get a full IDLE→DONE sequence. The DONE cycle guarantees the following instruction is decoded fresh in IDLE, even when it is bit-identical to the previous one.
- The counter saturates at `TIMEOUT` and does not wrap.

## Test plan

1. **Store with immediate grant.** Reset, then `Ins` = SW, `Result` = 5, `Rdata2` = 32'hDEADBEEF, with `mem_gnt` = 1 throughout.
   - `mem_req` = 1 with addr 5, we 1, wdata DEADBEEF in cycle 2.
   - `Stall` = 1,1,0 over cycles 1–3.
2. **Load with delayed grant and response.** LW with `Result` = 7; `mem_gnt` arrives after 2 cycles; `mem_rvalid` arrives 3 cycles after grant with data 32'h12345678.
   - `mem_addr` is held at 7 across the grant wait.
   - In the DONE cycle, `Wdata` = 12345678 and `Stall` = 0.
   - Total of 7 stall cycles.
3. **Load timeout.** LW with `TIMEOUT` = 4 and `mem_rvalid` never asserted.
   - `Err` pulses once on the 4th WAIT cycle.
   - DONE follows with `Wdata` = 0.
   - Return to IDLE.
4. **Non-memory instructions.** ADD with `Result` = 9, JAL with `nextPC` = 32'h40, then JALR with `nextPC` = 32'h44.
   - `Stall` = 0 throughout.
   - `Wdata` = 9, then 40, then 44.
   - `mem_req` never asserts.
5. **Reset during WAIT.** Assert `RST_N` = 0 for one edge during WAIT; then drive `mem_rvalid` = 1 with data AAAA.
   - After reset: state IDLE, `mem_req` = 0, `rdata_q` = 0.
   - The stale response is ignored.
   - A subsequent LW performs a complete new sequence.
6. **Identical back-to-back stores.** Two identical SW instructions back to back.
   - Two separate `mem_req` grants.
   - A `Stall` = 0 gap of exactly one cycle between them.
